// File: rtl/relogio_pkg.sv
// Shared types and defaults for the clock-setting logic.
// Holds the setting-FSM state encoding and counter sizing helpers.
package relogio_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HOR = 2'd1,
        SET_MIN = 2'd2,
        SET_SEG = 2'd3
    } estado_t;

    localparam int TIMEOUT_S_DEF    = 10;
    localparam int REPEAT_DELAY_DEF = 2;

    // Width that holds 0..max_val; at least one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic estado_t proximo(input estado_t e);
        case (e)
            RUN:     return SET_HOR;
            SET_HOR: return SET_MIN;
            SET_MIN: return SET_SEG;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/sincroniza_botao.sv
// Two-flop synchronizer for an asynchronous button level, followed by a
// registered rising-edge detector producing a single-cycle press pulse.
module sincroniza_botao (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic nivel_o,
    output logic pulso_o
);

    // sync_q[0..1] are the synchronizer flops, sync_q[2] the previous level.
    logic [2:0] sync_q;
    logic       pulso_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 3'b000;
            pulso_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], btn_i};
            pulso_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign nivel_o = sync_q[1];
    assign pulso_o = pulso_q;

endmodule

// File: rtl/ajuste_hora.sv
// Time-setting controller: mode button walks RUN -> hours -> minutes ->
// seconds, increment button emits adjust pulses with hold-to-repeat.
module ajuste_hora
    import relogio_pkg::*;
#(
    parameter int TIMEOUT_S    = TIMEOUT_S_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF
) (
    input  logic       ajuste_clock,
    input  logic       ajuste_reset,
    input  logic       ajuste_enable,
    input  logic       ajuste_btn_modo,
    input  logic       ajuste_btn_inc,
    output logic       ajuste_run,
    output logic       ajuste_add_min,
    output logic       ajuste_add_hor,
    output logic       ajuste_clr_seg,
    output logic [2:0] ajuste_blink,
    output logic [1:0] ajuste_estado
);

    localparam int TW = cnt_width(TIMEOUT_S);
    localparam int RW = cnt_width(REPEAT_DELAY);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_S);
    localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_DELAY);

    logic modo_nivel, modo_p;
    logic inc_nivel, inc_p;

    sincroniza_botao u_sync_modo (
        .clk_i   (ajuste_clock),
        .rst_i   (ajuste_reset),
        .btn_i   (ajuste_btn_modo),
        .nivel_o (modo_nivel),
        .pulso_o (modo_p)
    );

    sincroniza_botao u_sync_inc (
        .clk_i   (ajuste_clock),
        .rst_i   (ajuste_reset),
        .btn_i   (ajuste_btn_inc),
        .nivel_o (inc_nivel),
        .pulso_o (inc_p)
    );

    estado_t       estado_q, estado_d;
    logic [TW-1:0] to_q, to_d;
    logic [RW-1:0] hold_q, hold_d;
    logic          fase_q, fase_d;
    logic          add_hor_q, add_hor_d;
    logic          add_min_q, add_min_d;
    logic          clr_seg_q, clr_seg_d;
    logic          repete;

    assign repete = ajuste_enable && inc_nivel && (hold_q >= RP_MAX) &&
                    ((estado_q == SET_HOR) || (estado_q == SET_MIN));

    always_ff @(posedge ajuste_clock) begin
        if (ajuste_reset) begin
            estado_q  <= RUN;
            to_q      <= '0;
            hold_q    <= '0;
            fase_q    <= 1'b0;
            add_hor_q <= 1'b0;
            add_min_q <= 1'b0;
            clr_seg_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            to_q      <= to_d;
            hold_q    <= hold_d;
            fase_q    <= fase_d;
            add_hor_q <= add_hor_d;
            add_min_q <= add_min_d;
            clr_seg_q <= clr_seg_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        to_d      = to_q;
        hold_d    = hold_q;
        fase_d    = fase_q;
        add_hor_d = 1'b0;
        add_min_d = 1'b0;
        clr_seg_d = 1'b0;

        if (estado_q == RUN) begin
            to_d   = '0;
            hold_d = '0;
            fase_d = 1'b0;
            if (modo_p) begin
                estado_d = SET_HOR;
            end
        end else if (modo_p) begin
            // Mode wins over a coincident increment press.
            estado_d = proximo(estado_q);
            to_d     = '0;
            hold_d   = '0;
            fase_d   = 1'b0;
        end else if (to_q == TO_MAX) begin
            estado_d = RUN;
            to_d     = '0;
            hold_d   = '0;
            fase_d   = 1'b0;
        end else begin
            if (ajuste_enable) begin
                fase_d = ~fase_q;
            end

            if (inc_p || inc_nivel) begin
                to_d = '0;
            end else if (ajuste_enable) begin
                to_d = to_q + TW'(1);
            end

            if (!inc_nivel || (estado_q == SET_SEG)) begin
                hold_d = '0;
            end else if (ajuste_enable && (hold_q != RP_MAX)) begin
                hold_d = hold_q + RW'(1);
            end

            if (inc_p || repete) begin
                case (estado_q)
                    SET_HOR: add_hor_d = 1'b1;
                    SET_MIN: add_min_d = 1'b1;
                    SET_SEG: clr_seg_d = inc_p;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ajuste_blink = 3'b000;
        case (estado_q)
            SET_HOR: ajuste_blink = {fase_q, 2'b00};
            SET_MIN: ajuste_blink = {1'b0, fase_q, 1'b0};
            SET_SEG: ajuste_blink = {2'b00, fase_q};
            default: ajuste_blink = 3'b000;
        endcase
    end

    assign ajuste_run     = (estado_q == RUN);
    assign ajuste_estado  = estado_q;
    assign ajuste_add_hor = add_hor_q;
    assign ajuste_add_min = add_min_q;
    assign ajuste_clr_seg = clr_seg_q;

endmodule

// File: tb/tb_ajuste_hora.sv
// Directed bench for ajuste_hora: mode sequencing, press latency, auto-repeat,
// timeout, coincident presses and reset while a button is held.
module tb_ajuste_hora;

    logic       ajuste_clock = 1'b0;
    logic       ajuste_reset = 1'b1;
    logic       ajuste_enable = 1'b0;
    logic       ajuste_btn_modo = 1'b0;
    logic       ajuste_btn_inc = 1'b0;
    logic       ajuste_run;
    logic       ajuste_add_min;
    logic       ajuste_add_hor;
    logic       ajuste_clr_seg;
    logic [2:0] ajuste_blink;
    logic [1:0] ajuste_estado;

    int n_chk  = 0;
    int n_fail = 0;
    logic [2:0] exp_q[$];

    ajuste_hora #(.TIMEOUT_S(10), .REPEAT_DELAY(2)) dut (
        .ajuste_clock    (ajuste_clock),
        .ajuste_reset    (ajuste_reset),
        .ajuste_enable   (ajuste_enable),
        .ajuste_btn_modo (ajuste_btn_modo),
        .ajuste_btn_inc  (ajuste_btn_inc),
        .ajuste_run      (ajuste_run),
        .ajuste_add_min  (ajuste_add_min),
        .ajuste_add_hor  (ajuste_add_hor),
        .ajuste_clr_seg  (ajuste_clr_seg),
        .ajuste_blink    (ajuste_blink),
        .ajuste_estado   (ajuste_estado)
    );

    // Clock / reset
    always #5 ajuste_clock = ~ajuste_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: all inputs change 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge ajuste_clock);
            #1;
        end
    endtask

    task automatic tick();
        ajuste_enable = 1'b1;
        step(1);
        ajuste_enable = 1'b0;
    endtask

    task automatic press_modo();
        ajuste_btn_modo = 1'b1;
        step(4);
        ajuste_btn_modo = 1'b0;
        step(4);
    endtask

    // Scoreboard: every observed pulse must match the next expected code {hor,min,seg}.
    always @(negedge ajuste_clock) begin
        logic [2:0] obs;
        logic [2:0] exp;
        obs = {ajuste_add_hor, ajuste_add_min, ajuste_clr_seg};
        if (obs != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("pulse_extra", 32'(obs), 32'd0);
            end else begin
                exp = exp_q.pop_front();
                check("pulse_code", 32'(obs), 32'(exp));
            end
        end
    end

    initial begin
        // Reset state
        step(3);
        check("rst_estado", 32'(ajuste_estado), 32'd0);
        check("rst_run", 32'(ajuste_run), 32'd1);
        check("rst_blink", 32'(ajuste_blink), 32'd0);
        check("rst_pulses", 32'({ajuste_add_hor, ajuste_add_min, ajuste_clr_seg}), 32'd0);
        ajuste_reset = 1'b0;
        step(2);

        // Mode sequencing and blink per field
        press_modo();
        check("seq_estado1", 32'(ajuste_estado), 32'd1);
        check("seq_run1", 32'(ajuste_run), 32'd0);
        check("seq_blink_hor0", 32'(ajuste_blink), 32'd0);
        tick();
        check("seq_blink_hor1", 32'(ajuste_blink), 32'b100);
        tick();
        check("seq_blink_hor2", 32'(ajuste_blink), 32'b000);
        press_modo();
        check("seq_estado2", 32'(ajuste_estado), 32'd2);
        tick();
        check("seq_blink_min", 32'(ajuste_blink), 32'b010);
        press_modo();
        check("seq_estado3", 32'(ajuste_estado), 32'd3);
        tick();
        check("seq_blink_seg", 32'(ajuste_blink), 32'b001);
        press_modo();
        check("seq_estado0", 32'(ajuste_estado), 32'd0);
        check("seq_run0", 32'(ajuste_run), 32'd1);
        check("seq_blink_run", 32'(ajuste_blink), 32'd0);

        // Increment in RUN is ignored
        ajuste_btn_inc = 1'b1;
        step(6);
        ajuste_btn_inc = 1'b0;
        step(4);
        check("run_inc_estado", 32'(ajuste_estado), 32'd0);

        // Single increment in SET_MIN, exact latency
        press_modo();
        press_modo();
        check("min_estado", 32'(ajuste_estado), 32'd2);
        exp_q.push_back(3'b010);
        ajuste_btn_inc = 1'b1;
        step(3);
        check("min_lat_early", 32'(ajuste_add_min), 32'd0);
        step(1);
        check("min_lat_hit", 32'(ajuste_add_min), 32'd1);
        check("min_lat_hor", 32'(ajuste_add_hor), 32'd0);
        check("min_lat_seg", 32'(ajuste_clr_seg), 32'd0);
        step(1);
        check("min_lat_late", 32'(ajuste_add_min), 32'd0);
        ajuste_btn_inc = 1'b0;
        step(4);

        // Coincident mode + inc in SET_MIN: mode wins, SET_SEG never repeats
        ajuste_btn_modo = 1'b1;
        ajuste_btn_inc  = 1'b1;
        step(4);
        check("both_estado", 32'(ajuste_estado), 32'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
            step(2);
        end
        ajuste_btn_modo = 1'b0;
        ajuste_btn_inc  = 1'b0;
        step(4);
        check("both_estado_hold", 32'(ajuste_estado), 32'd3);

        // Timeout from a fresh SET_SEG entry
        press_modo();
        check("to_pre_run", 32'(ajuste_estado), 32'd0);
        press_modo();
        press_modo();
        press_modo();
        check("to_estado_seg", 32'(ajuste_estado), 32'd3);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("to_blink_t%0d", k), 32'(ajuste_blink), 32'(k % 2));
            check($sformatf("to_estado_t%0d", k), 32'(ajuste_estado), 32'd3);
            step(1);
        end
        tick();
        check("to_blink_t10", 32'(ajuste_blink), 32'd0);
        step(1);
        check("to_estado_exit", 32'(ajuste_estado), 32'd0);
        check("to_run_exit", 32'(ajuste_run), 32'd1);
        check("to_blink_exit", 32'(ajuste_blink), 32'd0);

        // Auto-repeat in SET_HOR: press pulse plus repeats on ticks 3..5
        press_modo();
        check("rep_estado", 32'(ajuste_estado), 32'd1);
        exp_q.push_back(3'b100);
        ajuste_btn_inc = 1'b1;
        step(4);
        check("rep_press", 32'(ajuste_add_hor), 32'd1);
        step(2);
        for (int k = 1; k <= 5; k++) begin
            if (k >= 3) exp_q.push_back(3'b100);
            tick();
            check($sformatf("rep_tick%0d", k), 32'(ajuste_add_hor), (k >= 3) ? 32'd1 : 32'd0);
            step(2);
        end

        // Reset while inc is held in SET_HOR
        ajuste_reset = 1'b1;
        step(2);
        ajuste_reset = 1'b0;
        check("rst_mid_estado", 32'(ajuste_estado), 32'd0);
        check("rst_mid_run", 32'(ajuste_run), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            step(3);
        end
        ajuste_btn_inc = 1'b0;
        step(4);
        press_modo();
        check("rst_mid_sethor", 32'(ajuste_estado), 32'd1);
        check("rst_mid_nopulse", 32'(ajuste_add_hor), 32'd0);
        exp_q.push_back(3'b100);
        ajuste_btn_inc = 1'b1;
        step(4);
        check("rst_mid_fresh", 32'(ajuste_add_hor), 32'd1);
        ajuste_btn_inc = 1'b0;
        step(6);

        // Final report
        check("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ajuste_hora.md
AJUSTE_HORA -- requirements
Module: ajuste_hora

Interface
REQ-001 Parameter TIMEOUT_S, default 10: number of 1 Hz ticks with no button activity before a setting state returns to RUN.
REQ-002 Parameter REPEAT_DELAY, default 2: number of 1 Hz ticks the increment button must be held before auto-repeat starts.
REQ-003 ajuste_clock  in  1  system clock; the single clock of the block.
REQ-004 ajuste_reset  in  1  synchronous, active-high reset.
REQ-005 ajuste_enable  in  1  1 Hz single-cycle tick from enable_1hz.
REQ-006 ajuste_btn_modo  in  1  debounced mode button level, active-high, asynchronous to ajuste_clock.
REQ-007 ajuste_btn_inc  in  1  debounced increment button level, active-high, asynchronous to ajuste_clock.
REQ-008 ajuste_run  out  1  1 = timekeeping runs; the top level ANDs this with the 1 Hz tick feeding the counters.
REQ-009 ajuste_add_min  out  1  single-cycle minute increment pulse.
REQ-010 ajuste_add_hor  out  1  single-cycle hour increment pulse.
REQ-011 ajuste_clr_seg  out  1  single-cycle pulse that clears the seconds counter.
REQ-012 ajuste_blink  out  3  blank mask {hor,min,seg}; 1 = blank that display pair.
REQ-013 ajuste_estado  out  2  current state encoding.

Function
REQ-014 Each button input passes through a 2-FF synchronizer, then rising-edge detection; the resulting press pulse is registered.
REQ-015 Latency: an output pulse caused by a press is high exactly one cycle, on the 3rd clock edge after the first edge that samples the button high.
REQ-016 FSM states: RUN=0, SET_HOR=1, SET_MIN=2, SET_SEG=3.
REQ-017 A mode press advances the state RUN->SET_HOR->SET_MIN->SET_SEG->RUN.
REQ-018 ajuste_run = 1 only in RUN.
REQ-019 Increment presses in RUN are ignored.
REQ-020 An increment press in SET_HOR pulses ajuste_add_hor; in SET_MIN it pulses ajuste_add_min; in SET_SEG it pulses ajuste_clr_seg.
REQ-021 Auto-repeat: while inc is held in SET_HOR or SET_MIN, hold-tick count >= REPEAT_DELAY yields one add pulse per ajuste_enable tick.
REQ-022 The hold count clears on inc release and on any state change; SET_SEG never repeats.
REQ-023 Simultaneous mode and inc press in the same cycle: mode wins and inc is discarded, including any repeat.
REQ-024 Timeout counter: counts ajuste_enable ticks in the set states and clears on any press or when inc is held.
REQ-025 When the timeout count reaches TIMEOUT_S, the next cycle enters RUN with no pulses emitted.
REQ-026 Blink phase: clears on entry to any set state and toggles on each ajuste_enable tick.
REQ-027 The selected field's blink bit = phase; all other bits are 0; ajuste_blink = 3'b000 in RUN.
REQ-028 Counter widths are sized from the parameters; counters saturate and never wrap.
REQ-029 At most one of add_hor, add_min and clr_seg is high in any cycle.

Reset
REQ-030 Reset to state RUN.
REQ-031 Output reset values: ajuste_run=1, all pulses 0, ajuste_blink=0, ajuste_estado=0.
REQ-032 All synchronizers, counters and the blink phase clear on reset.
REQ-033 Reset asserted mid-operation, in any state, takes priority over all inputs in that cycle.

Structure
REQ-034 Package relogio_pkg holds the estado_t enum and the TIMEOUT_S/REPEAT_DELAY defaults.
REQ-035 Sub-module sincroniza_botao (synchronizer plus edge detect) is instantiated twice.

Verification
REQ-036 Reset, then three mode presses -> estado goes 1,2,3; ajuste_run=0 after the first press; a fourth press -> estado=0 and ajuste_run=1.
REQ-037 SET_MIN, one inc press -> exactly one ajuste_add_min pulse, 3 clocks after the sampled press; add_hor and clr_seg stay 0.
REQ-038 SET_HOR, inc held for 5 ticks with REPEAT_DELAY=2 -> 1 press pulse plus 3 repeat pulses on ticks 3, 4 and 5.
REQ-039 SET_SEG, 10 ticks idle -> estado=0 on tick 10; blink {0,0,x} toggles every tick beforehand and is 0 afterwards.
REQ-040 Mode and inc rising in the same cycle in SET_MIN -> estado=3 and no add_min pulse.
REQ-041 Reset asserted in SET_HOR while inc is held -> RUN; no pulses until a fresh press after release.
